// File: rtl/esc_spi_cs_ctrl.sv
// Avalon-MM chip-select controller for the ESC SPI master: setup delay, min CS-high gap,
// one-hot enforcement, sticky status. Optional ESC_SPI_CS_TIMEOUT_EN adds an ACTIVE-time timeout.
module esc_spi_cs_ctrl #(
  parameter int          NUM_CS        = 4,
  parameter logic [15:0] SETUP_DEFAULT = 16'd4,
  parameter logic [15:0] GAP_DEFAULT   = 16'd4,
  parameter int          ONE_HOT       = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [NUM_CS-1:0] cs_n,
  output logic              cs_ready
);

  typedef enum logic [1:0] {IDLE, SETUP, ACTIVE, GAP} state_t;

  state_t            state, state_nxt;
  logic [15:0]       cnt, cnt_nxt, setup_q, gap_q;
  logic [NUM_CS-1:0] applied, applied_nxt, pending, pending_nxt, wmask, req;
  logic              ready_nxt, err, err_set, tmo, to_hit;
  logic              wr, mask_wr, multi_hot, busy, load, go_active, go_gap;

  assign wr        = chipselect & ~write_n;
  assign wmask     = writedata[NUM_CS-1:0];
  assign multi_hot = (wmask & (wmask - NUM_CS'(1))) != '0;
  assign err_set   = wr && address == 2'd0 && ONE_HOT != 0 && multi_hot;
  assign mask_wr   = wr && address == 2'd0 && !(ONE_HOT != 0 && multi_hot);
  assign busy      = state == SETUP || state == GAP;

`ifdef ESC_SPI_CS_TIMEOUT_EN
  logic [31:0] timeout_q, tcnt;

  // tcnt holds the number of completed ACTIVE cycles; fire on the edge that completes TIMEOUT of them
  assign to_hit = state == ACTIVE && timeout_q != 32'd0 && tcnt + 32'd1 == timeout_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_q <= '0;
      tcnt      <= '0;
      tmo       <= 1'b0;
    end else begin
      if (wr && address == 2'd3) timeout_q <= writedata;
      if (go_active) tcnt <= '0;
      else if (state == ACTIVE && tcnt != '1) tcnt <= tcnt + 32'd1;
      tmo <= (tmo & ~(wr && address == 2'd2 && writedata[3])) | to_hit;
    end
  end
`else
  assign to_hit = 1'b0;
  assign tmo    = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    applied_nxt = applied;
    pending_nxt = pending;
    ready_nxt   = cs_ready;
    load        = 1'b0;
    go_active   = 1'b0;
    go_gap      = 1'b0;
    // a write this cycle supersedes whatever was pending
    req = mask_wr ? wmask : pending;
    if (mask_wr) pending_nxt = wmask;
    case (state)
      IDLE: begin
        if (mask_wr && wmask != '0) begin
          applied_nxt = wmask;
          load        = 1'b1;
        end
      end
      SETUP: begin
        if (cnt <= 16'd1) go_active = 1'b1;
        else cnt_nxt = cnt - 16'd1;
      end
      ACTIVE: begin
        if (to_hit) begin
          pending_nxt = '0;
          go_gap      = 1'b1;
        end else if (req != applied) begin
          go_gap = 1'b1;
        end
      end
      GAP: begin
        if (cnt <= 16'd1) begin
          if (req != '0) begin
            applied_nxt = req;
            load        = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (load) begin
      if (setup_q == 16'd0) go_active = 1'b1;
      else begin
        state_nxt = SETUP;
        cnt_nxt   = setup_q;
      end
    end
    if (go_active) begin
      state_nxt = ACTIVE;
      ready_nxt = 1'b1;
    end
    if (go_gap) begin
      state_nxt   = GAP;
      cnt_nxt     = gap_q;
      applied_nxt = '0;
      ready_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      applied  <= '0;
      pending  <= '0;
      cs_n     <= '1;
      cs_ready <= 1'b0;
      setup_q  <= SETUP_DEFAULT;
      gap_q    <= GAP_DEFAULT;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      applied  <= applied_nxt;
      pending  <= pending_nxt;
      cs_n     <= ~applied_nxt;
      cs_ready <= ready_nxt;
      if (wr && address == 2'd1) begin
        setup_q <= writedata[15:0];
        gap_q   <= writedata[31:16];
      end
      err <= (err & ~(wr && address == 2'd2 && writedata[2])) | err_set;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata[NUM_CS-1:0] = applied;
      2'd1: readdata = {gap_q, setup_q};
      2'd2: readdata[3:0] = {tmo, err, cs_ready, busy};
`ifdef ESC_SPI_CS_TIMEOUT_EN
      2'd3: readdata = timeout_q;
`endif
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_esc_spi_cs_ctrl.sv
// Scoreboard bench for esc_spi_cs_ctrl: per-cycle pin expectations and register reads are
// queued when stimulus is driven and compared as the DUT produces them.
module tb_esc_spi_cs_ctrl;
  logic        clk = 1'b0, reset = 1'b1, chipselect = 1'b0, write_n = 1'b1;
  logic [1:0]  address = '0;
  logic [31:0] writedata = '0, readdata;
  logic [3:0]  cs_n;
  logic        cs_ready;
  int          n_chk = 0, n_err = 0;

  typedef struct { string tag; logic [4:0] v; } pin_t;
  pin_t        pq[$];
  logic [31:0] rq[$];

  esc_spi_cs_ctrl #(.NUM_CS(4)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .cs_n(cs_n), .cs_ready(cs_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pexp(input string tag, input logic [3:0] c, input logic r, input int n);
    pin_t e;
    e.tag = tag;
    e.v   = {c, r};
    for (int i = 0; i < n; i++) pq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (pq.size() != 0) begin
      pin_t e = pq.pop_front();
      chk(e.tag, {27'b0, cs_n, cs_ready}, {27'b0, e.v});
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    rq.push_back(exp);
    #1;
    chk(tag, readdata, rq.pop_front());
    chipselect = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    pexp("rst_pins", 4'hF, 1'b0, 1);
    tick();
    rd("rst_mask", 2'd0, 32'h0);
    rd("rst_timing", 2'd1, 32'h0004_0004);
    rd("rst_status", 2'd2, 32'h0);
    rd("rst_timeout", 2'd3, 32'h0);

    // setup delay of 4 after cs_n falls
    pexp("setup_wait", 4'b1101, 1'b0, 4);
    pexp("setup_rdy", 4'b1101, 1'b1, 2);
    wr(2'd0, 32'h2);
    tick();
    rd("setup_busy", 2'd2, 32'h1);
    repeat (4) tick();
    rd("setup_mask", 2'd0, 32'h2);
    rd("setup_status", 2'd2, 32'h2);

    // switch: 4-cycle gap then 4-cycle setup for new mask
    pexp("sw_gap", 4'hF, 1'b0, 4);
    pexp("sw_setup", 4'b0111, 1'b0, 4);
    pexp("sw_rdy", 4'b0111, 1'b1, 2);
    wr(2'd0, 32'h8);
    repeat (9) tick();
    rd("sw_mask", 2'd0, 32'h8);

    // one-hot rejection, err clear, out-of-range bits ignored
    pexp("oh_hold", 4'b0111, 1'b1, 1);
    wr(2'd0, 32'h3);
    rd("oh_err", 2'd2, 32'h6);
    pexp("oh_clr_hold", 4'b0111, 1'b1, 1);
    wr(2'd2, 32'h4);
    rd("oh_cleared", 2'd2, 32'h2);
    pexp("hi_bits_hold", 4'b0111, 1'b1, 1);
    wr(2'd0, 32'h18);
    rd("hi_bits_mask", 2'd0, 32'h8);

    // release to IDLE, then zero timing
    pexp("rel_gap", 4'hF, 1'b0, 5);
    wr(2'd0, 32'h0);
    repeat (4) tick();
    rd("rel_idle", 2'd2, 32'h0);
    pexp("zt_idle", 4'hF, 1'b0, 1);
    wr(2'd1, 32'h0);
    rd("zt_timing", 2'd1, 32'h0);
    pexp("zt_act", 4'b1110, 1'b1, 2);
    wr(2'd0, 32'h1);
    tick();
    rd("zt_status", 2'd2, 32'h2);
    pexp("zt_gap1", 4'hF, 1'b0, 1);
    wr(2'd0, 32'h0);
    rd("zt_gap_busy", 2'd2, 32'h1);
    pexp("zt_idle2", 4'hF, 1'b0, 1);
    tick();
    rd("zt_idle_st", 2'd2, 32'h0);

    // write during gap: latest wins
    pexp("lw_act", 4'b1110, 1'b1, 1);
    wr(2'd0, 32'h1);
    pexp("lw_gap", 4'hF, 1'b0, 1);
    wr(2'd0, 32'h2);
    pexp("lw_new", 4'b1011, 1'b1, 1);
    wr(2'd0, 32'h4);
    rd("lw_mask", 2'd0, 32'h4);

    // write during setup differing from applied: 1-cycle cs_ready pulse then switch
    pexp("sp_tim", 4'b1011, 1'b1, 1);
    wr(2'd1, 32'h0000_0003);
    pexp("sp_gap", 4'hF, 1'b0, 1);
    pexp("sp_setup", 4'b1110, 1'b0, 3);
    pexp("sp_pulse", 4'b1110, 1'b1, 1);
    pexp("sp_gap2", 4'hF, 1'b0, 1);
    pexp("sp_setup2", 4'b1101, 1'b0, 3);
    pexp("sp_rdy2", 4'b1101, 1'b1, 1);
    wr(2'd0, 32'h1);
    tick();
    tick();
    wr(2'd0, 32'h2);
    repeat (6) tick();

    // reset mid-frame
    pexp("mid_rst", 4'hF, 1'b0, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd("mid_rst_mask", 2'd0, 32'h0);
    rd("mid_rst_timing", 2'd1, 32'h0004_0004);
    rd("mid_rst_status", 2'd2, 32'h0);

`ifdef ESC_SPI_CS_TIMEOUT_EN
    pexp("to_cfg", 4'hF, 1'b0, 1);
    wr(2'd3, 32'd10);
    rd("to_reg", 2'd3, 32'd10);
    pexp("to_setup", 4'b1110, 1'b0, 4);
    pexp("to_act", 4'b1110, 1'b1, 10);
    pexp("to_fire", 4'hF, 1'b0, 5);
    wr(2'd0, 32'h1);
    repeat (14) tick();
    rd("to_gap_st", 2'd2, 32'h9);
    repeat (4) tick();
    rd("to_idle_st", 2'd2, 32'h8);
    wr(2'd2, 32'h8);
    rd("to_clr", 2'd2, 32'h0);
`else
    pexp("a3_idle", 4'hF, 1'b0, 1);
    wr(2'd3, 32'd10);
    rd("a3_ignored", 2'd3, 32'h0);
`endif

    chk("pin_queue_drained", pq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
